// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the automatic clock-gate controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STOP_REQ = 2'd1,
        GATED    = 2'd2,
        WAKE     = 2'd3
    } clk_gate_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Automatic clock-gate controller: idle detection, stop handshake and settled wake-up
// for one gated sub-domain. Runs on the free-running clock upstream of the gating cell.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IdleCycles  = 16,
    parameter int WakeLatency = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic test_mode_i,
    input  logic auto_en_i,
    input  logic busy_i,
    input  logic wake_req_i,
    output logic stop_req_o,
    input  logic stop_ack_i,
    output logic clk_en_o,
    output logic gated_o,
    output logic wake_ack_o
);

    localparam int CntWidth = $clog2(max_int(IdleCycles, WakeLatency) + 1);
    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WakeLatency - 1);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    clk_gate_state_e     state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                wake_ack_q, wake_ack_d;
    logic                idle;

    assign idle = auto_en_i & ~busy_i & ~wake_req_i & ~test_mode_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wake_ack_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!idle) begin
                    cnt_d = '0;
                end else if (cnt_q == IdleLast) begin
                    state_d = STOP_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            STOP_REQ: begin
                cnt_d = '0;
                // Any loss of idleness wins over a simultaneous stop_ack.
                if (!idle) begin
                    state_d = RUN;
                end else if (stop_ack_i) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                cnt_d = '0;
                if (!idle) begin
                    state_d = WAKE;
                    cnt_d   = WakeLoad;
                end
            end
            WAKE: begin
                if (cnt_q == '0) begin
                    state_d    = RUN;
                    wake_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wake_ack_q <= wake_ack_d;
        end
    end

    // Outputs decode the state flop only, so reset forces the clock on without an edge.
    assign clk_en_o   = (state_q != GATED);
    assign stop_req_o = (state_q == STOP_REQ);
    assign gated_o    = (state_q == GATED);
    assign wake_ack_o = wake_ack_q;

endmodule
